unidade_controle_multiciclo: RTL and testbench

Multicycle control unit FSM for the datapath; it is the producer of every datapath select and write-enable, including `ALUSrcB` consumed by the ALU B-operand mux. It decodes `opcode`/`funct` from the instruction register and steps a per-instruction state sequence (fetch, decode, execute, memory, writeback). Memory accesses honour a fixed, parameterised read/write latency via an internal wait counter.

---
 rtl/unidade_controle_multiciclo.sv | 206 ++++++++++++++++++++
 tb/tb_unidade_controle_multiciclo.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle control unit: fetch/decode/execute FSM driving every datapath enable.
// Build with EXCECAO_EN defined to trap overflow and undefined instructions.
module unidade_controle_multiciclo #(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       EPCWrite,
  output logic       excecao,
  output logic [3:0] estado
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC_R  = 4'd2,
    S_WB_R    = 4'd3,
    S_MEMADDR = 4'd4,
    S_MEMREAD = 4'd5,
    S_WB_MEM  = 4'd6,
    S_MEMWR   = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_EXEC_I  = 4'd10,
    S_WB_I    = 4'd11,
    S_UNDEF   = 4'd12
  } state_e;

  localparam logic [2:0] MW = 3'(MEM_WAIT);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       mem_done;
  logic       funct_ok;
  logic       arith_r;
  logic       ovf_trap;
  logic [2:0] alu_r;
  logic       unused_zero;

  assign unused_zero = zero;
  assign mem_done    = (cnt_q == MW);
  assign arith_r     = (funct == 6'h20) || (funct == 6'h22);
  assign estado      = state_q;

`ifdef EXCECAO_EN
  assign ovf_trap = overflow;
`else
  logic unused_ovf;
  assign unused_ovf = overflow;
  assign ovf_trap   = 1'b0;
`endif

  always_comb begin
    alu_r    = 3'b000;
    funct_ok = 1'b1;
    unique case (funct)
      6'h20:   alu_r = 3'b000;
      6'h22:   alu_r = 3'b001;
      6'h24:   alu_r = 3'b010;
      6'h25:   alu_r = 3'b011;
      6'h2A:   alu_r = 3'b100;
      default: funct_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are forced low while reset is held so no enable can glitch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = 3'd0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 3'b000;
    PCSource    = 2'b00;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    EPCWrite    = 1'b0;
    excecao     = 1'b0;
    if (reset_n) begin
      unique case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          if (mem_done) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            ALUSrcB = 2'b01;
            state_d = S_DECODE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
          unique case (opcode)
            6'h00:        state_d = S_EXEC_R;
            6'h23, 6'h2B: state_d = S_MEMADDR;
            6'h04:        state_d = S_BRANCH;
            6'h02:        state_d = S_JUMP;
            6'h08:        state_d = S_EXEC_I;
            default:      state_d = S_UNDEF;
          endcase
        end
        S_EXEC_R: begin
          ALUSrcA = 1'b1;
          ALUOp   = alu_r;
          if (!funct_ok || (ovf_trap && arith_r))
            state_d = S_UNDEF;
          else
            state_d = S_WB_R;
        end
        S_WB_R: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
          state_d  = S_FETCH;
        end
        S_MEMADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          state_d = (opcode == 6'h23) ? S_MEMREAD : S_MEMWR;
        end
        S_MEMREAD: begin
          IorD    = 1'b1;
          MemRead = 1'b1;
          if (mem_done) state_d = S_WB_MEM;
          else          cnt_d   = cnt_q + 3'd1;
        end
        S_WB_MEM: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
          state_d  = S_FETCH;
        end
        S_MEMWR: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
          if (mem_done) state_d = S_FETCH;
          else          cnt_d   = cnt_q + 3'd1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 3'b001;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          state_d     = S_FETCH;
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
          state_d  = S_FETCH;
        end
        S_EXEC_I: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          state_d = ovf_trap ? S_UNDEF : S_WB_I;
        end
        S_WB_I: begin
          RegWrite = 1'b1;
          state_d  = S_FETCH;
        end
        S_UNDEF: begin
`ifdef EXCECAO_EN
          EPCWrite = 1'b1;
          PCSource = 2'b11;
          PCWrite  = 1'b1;
          excecao  = 1'b1;
`endif
          state_d  = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Scoreboard bench for the multicycle control unit: a per-cycle output
// trace is predicted per instruction and checked by an independent monitor.
module tb_unidade_controle_multiciclo;

  localparam int MW = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] opcode, funct;
  logic       zero, overflow;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic [1:0] PCSource;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, EPCWrite, excecao;
  logic [3:0] estado;

  always #5 clk = ~clk;

  unidade_controle_multiciclo #(.MEM_WAIT(MW)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct),
    .zero(zero), .overflow(overflow), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSource(PCSource), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .RegWrite(RegWrite), .EPCWrite(EPCWrite),
    .excecao(excecao), .estado(estado)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       srca;
    logic [1:0] srcb;
    logic [2:0] op;
    logic [1:0] pcs;
    logic       pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, epcw, exc;
  } ov_t;

  ov_t act;
  assign act = {estado, ALUSrcA, ALUSrcB, ALUOp, PCSource, PCWrite,
                PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                RegDst, RegWrite, EPCWrite, excecao};

  ov_t expq[$];
  int  n_run = 0;
  int  n_fail = 0;
  int  exp_len;
  bit  en_exc;

  task automatic check(input string nm, input ov_t e);
    n_run++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s t=%0t got %h required %h (estado got %0d required %0d)",
               nm, $time, act, e, act.st, e.st);
    end
  endtask

  always @(negedge clk) begin : monitor
    ov_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      check("trace", e);
    end
  end

  function automatic ov_t z(input int s);
    ov_t o;
    o = '0;
    o.st = 4'(s);
    return o;
  endfunction

  function automatic void put(input ov_t o);
    expq.push_back(o);
    exp_len++;
  endfunction

  function automatic ov_t trap();
    ov_t o;
    o = z(12);
    if (en_exc) begin
      o.epcw = 1'b1; o.pcs = 2'b11; o.pcw = 1'b1; o.exc = 1'b1;
    end
    return o;
  endfunction

  // Reference trace built from instruction class, not from FSM encoding.
  function automatic void model(input logic [5:0] op, input logic [5:0] fn,
                                input logic ovf);
    ov_t o;
    bit known;
    logic [2:0] aop;
    for (int i = 0; i < MW; i++) begin
      o = z(0); o.mr = 1'b1; put(o);
    end
    o = z(0); o.mr = 1'b1; o.irw = 1'b1; o.pcw = 1'b1; o.srcb = 2'b01; put(o);
    o = z(1); o.srcb = 2'b11; put(o);
    case (op)
      6'h00: begin
        known = 1'b1;
        case (fn)
          6'h20: aop = 3'd0;
          6'h22: aop = 3'd1;
          6'h24: aop = 3'd2;
          6'h25: aop = 3'd3;
          6'h2A: aop = 3'd4;
          default: begin known = 1'b0; aop = 3'd0; end
        endcase
        o = z(2); o.srca = 1'b1; o.op = aop; put(o);
        if (!known || (en_exc && ovf && (fn == 6'h20 || fn == 6'h22)))
          put(trap());
        else begin
          o = z(3); o.rd = 1'b1; o.rw = 1'b1; put(o);
        end
      end
      6'h23, 6'h2B: begin
        o = z(4); o.srca = 1'b1; o.srcb = 2'b10; put(o);
        for (int i = 0; i <= MW; i++) begin
          o = z(op == 6'h23 ? 5 : 7);
          o.iord = 1'b1;
          if (op == 6'h23) o.mr = 1'b1; else o.mw = 1'b1;
          put(o);
        end
        if (op == 6'h23) begin
          o = z(6); o.m2r = 1'b1; o.rw = 1'b1; put(o);
        end
      end
      6'h04: begin
        o = z(8); o.srca = 1'b1; o.op = 3'd1; o.pcwc = 1'b1; o.pcs = 2'b01;
        put(o);
      end
      6'h02: begin
        o = z(9); o.pcw = 1'b1; o.pcs = 2'b10; put(o);
      end
      6'h08: begin
        o = z(10); o.srca = 1'b1; o.srcb = 2'b10; put(o);
        if (en_exc && ovf) put(trap());
        else begin
          o = z(11); o.rw = 1'b1; put(o);
        end
      end
      default: put(trap());
    endcase
  endfunction

  task automatic run(input logic [5:0] op, input logic [5:0] fn,
                     input logic ovf);
    opcode = op; funct = fn; overflow = ovf; zero = 1'($urandom_range(0, 1));
    exp_len = 0;
    model(op, fn, ovf);
    repeat (exp_len) @(posedge clk);
    #1;
  endtask

  logic [5:0] ftab [5];
  logic [5:0] rop, rfn;

  initial begin
`ifdef EXCECAO_EN
    en_exc = 1'b1;
`else
    en_exc = 1'b0;
`endif
    ftab[0] = 6'h20; ftab[1] = 6'h22; ftab[2] = 6'h24;
    ftab[3] = 6'h25; ftab[4] = 6'h2A;
    reset_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; overflow = 1'b0;
    for (int i = 0; i < 3; i++) expq.push_back(z(0));
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b1;

    run(6'h00, 6'h20, 1'b0);
    run(6'h23, 6'h00, 1'b0);
    run(6'h04, 6'h11, 1'b0);
    run(6'h02, 6'h07, 1'b0);
    run(6'h08, 6'h00, 1'b1);
    run(6'h3F, 6'h00, 1'b0);
    run(6'h00, 6'h22, 1'b1);
    run(6'h00, 6'h3F, 1'b0);
    run(6'h2B, 6'h00, 1'b0);

    // sw interrupted by reset during its first MEMWRITE cycle
    opcode = 6'h2B; funct = 6'h00; overflow = 1'b0;
    exp_len = 0;
    model(6'h2B, 6'h00, 1'b0);
    while (expq.size() > MW + 4) void'(expq.pop_back());
    repeat (MW + 3) @(posedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check("rst_in_memwrite", z(0));
    @(posedge clk);
    #1 check("rst_held", z(0));
    reset_n = 1'b1;
    run(6'h00, 6'h25, 1'b0);

    for (int n = 0; n < 60; n++) begin
      rfn = 6'($urandom_range(0, 63));
      case ($urandom_range(0, 9))
        0: begin rop = 6'h00; rfn = ftab[$urandom_range(0, 4)]; end
        1: rop = 6'h00;
        2: rop = 6'h23;
        3: rop = 6'h2B;
        4: rop = 6'h04;
        5: rop = 6'h02;
        6, 7: rop = 6'h08;
        8: rop = 6'($urandom_range(0, 63));
        default: rop = 6'h3F;
      endcase
      run(rop, rfn, 1'($urandom_range(0, 2) == 0));
    end

    repeat (2) @(posedge clk);
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d trace entries left, required 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
